// File: rtl/metadata_stream_arbiter.sv
// Packet-granular round-robin arbiter feeding one AXI-Stream metadata inserter.
// Whole packets pass contiguously through a 2-entry output FIFO.
module metadata_stream_arbiter #(
  parameter int unsigned NUM_SRC      = 4,
  parameter bit          OVERRIDE_TID = 1'b1,
  parameter int unsigned SRC_W        = $clog2(NUM_SRC)
) (
  input  logic                   s_axis_aclk,
  input  logic                   s_axis_areset,
  input  logic                   arb_enable,
  input  logic [NUM_SRC-1:0]     s_axis_tvalid,
  output logic [NUM_SRC-1:0]     s_axis_tready,
  input  logic [NUM_SRC*512-1:0] s_axis_tdata,
  input  logic [NUM_SRC*64-1:0]  s_axis_tkeep,
  input  logic [NUM_SRC*6-1:0]   s_axis_tid,
  input  logic [NUM_SRC-1:0]     s_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [511:0]           m_axis_tdata,
  output logic [63:0]            m_axis_tkeep,
  output logic [5:0]             m_axis_tid,
  output logic                   m_axis_tlast,
  output logic                   grant_valid,
  output logic [SRC_W-1:0]       grant_idx
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StBurst = 1'b1;
  localparam int unsigned EntW = 512 + 64 + 6 + 1;

  logic [0:0]       state_q, state_d;
  logic [SRC_W-1:0] grant_idx_q, grant_idx_d;
  logic [SRC_W-1:0] last_grant_q, last_grant_d;
  logic [EntW-1:0]  mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;

  logic             found;
  logic [SRC_W-1:0] pick;
  int unsigned      cand;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_SRC;
      if (!found && s_axis_tvalid[cand]) begin
        found = 1'b1;
        pick  = SRC_W'(cand);
      end
    end
  end

  logic           space, push, pop;
  logic [511:0]   sel_data;
  logic [63:0]    sel_keep;
  logic [5:0]     sel_tid;
  logic           sel_last;
  logic [EntW-1:0] entry;

  always_comb begin
    sel_data = s_axis_tdata[int'(grant_idx_q)*512 +: 512];
    sel_keep = s_axis_tkeep[int'(grant_idx_q)*64 +: 64];
    sel_tid  = OVERRIDE_TID ? 6'(grant_idx_q) : s_axis_tid[int'(grant_idx_q)*6 +: 6];
    sel_last = s_axis_tlast[grant_idx_q];
    entry    = {sel_data, sel_keep, sel_tid, sel_last};
  end

  // Ready depends only on registered state, never on m_axis_tready.
  assign space = (count_q < 2'd2);
  assign push  = (state_q == StBurst) && space && s_axis_tvalid[grant_idx_q];
  assign pop   = (count_q != 2'd0) && m_axis_tready;

  always_comb begin
    s_axis_tready = '0;
    if (state_q == StBurst && space) begin
      s_axis_tready[grant_idx_q] = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    last_grant_d = last_grant_q;
    case (state_q)
      StIdle: begin
        if (arb_enable && found) begin
          grant_idx_d = pick;
          state_d     = StBurst;
        end
      end
      StBurst: begin
        if (push && sel_last) begin
          last_grant_d = grant_idx_q;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state_q      <= StIdle;
      grant_idx_q  <= '0;
      last_grant_q <= SRC_W'(NUM_SRC - 1);
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge s_axis_aclk) begin
    if (push) mem_q[wr_ptr_q] <= entry;
  end

  assign m_axis_tvalid = (count_q != 2'd0);
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tid, m_axis_tlast} = mem_q[rd_ptr_q];
  assign grant_valid   = (state_q == StBurst);
  assign grant_idx     = grant_idx_q;

endmodule
